// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with bounded grant hold and turnaround idle
module rr_grant_arbiter #(
   parameter int DATA_W   = 16,
   parameter int POS_W    = 4,
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] req,
   output logic [DATA_W-1:0] grant,
   output logic [POS_W-1:0]  grant_pos,
   output logic              grant_valid,
   output logic [CNT_W-1:0]  hold_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_grant;
   logic [DATA_W-1:0]   w_grant_nxt;
   logic [POS_W-1:0]    r_grant_pos;
   logic [POS_W-1:0]    w_pos_nxt;
   logic                r_grant_valid;
   logic                w_valid_nxt;
   logic [CNT_W-1:0]    r_hold_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [POS_W-1:0]    r_last_pos;
   logic [POS_W-1:0]    w_last_nxt;
   logic [POS_W-1:0]    w_pick;
   logic [POS_W-1:0]    w_idx;
   logic                w_found;
   logic                w_release;

   // Wrap is modulo DATA_W; base < DATA_W and k <= DATA_W, so one subtraction suffices.
   function automatic logic [POS_W-1:0] wrap_add(input logic [POS_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= DATA_W) s = s - DATA_W;
      return s[POS_W-1:0];
   endfunction

   always_comb begin
      w_found = 1'b0;
      w_pick  = '1;
      w_idx   = '0;
      for (int k = 1; k <= DATA_W; k++) begin
         w_idx = wrap_add(r_last_pos, k);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   assign w_release = !req[r_grant_pos] || (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_pos_nxt   = r_grant_pos;
      w_valid_nxt = r_grant_valid;
      w_cnt_nxt   = r_hold_cnt;
      w_last_nxt  = r_last_pos;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt         = GRANT;
               w_grant_nxt         = '0;
               w_grant_nxt[w_pick] = 1'b1;
               w_pos_nxt           = w_pick;
               w_valid_nxt         = 1'b1;
               w_cnt_nxt           = '0;
            end
         end
         GRANT: begin
            // Other request bits are deliberately not looked at while a grant is held.
            if (w_release) begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
               w_pos_nxt   = '1;
               w_valid_nxt = 1'b0;
               w_cnt_nxt   = '0;
               w_last_nxt  = r_grant_pos;
            end else begin
               w_cnt_nxt = r_hold_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_grant_pos   <= '1;
         r_grant_valid <= 1'b0;
         r_hold_cnt    <= '0;
         r_last_pos    <= POS_W'(DATA_W - 1);
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_grant_pos   <= w_pos_nxt;
         r_grant_valid <= w_valid_nxt;
         r_hold_cnt    <= w_cnt_nxt;
         r_last_pos    <= w_last_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_pos   = r_grant_pos;
   assign grant_valid = r_grant_valid;
   assign hold_cnt    = r_hold_cnt;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] req;
   logic [15:0] grant;
   logic [3:0]  grant_pos;
   logic        grant_valid;
   logic [2:0]  hold_cnt;
   logic [23:0] obs;

   int n_pass;
   int n_total;

   rr_grant_arbiter #(
      .DATA_W(16),
      .POS_W(4),
      .MAX_HOLD(8),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .grant(grant),
      .grant_pos(grant_pos),
      .grant_valid(grant_valid),
      .hold_cnt(hold_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {grant, grant_pos, grant_valid, hold_cnt};

   // Expected {grant, grant_pos, grant_valid, hold_cnt}; g < 0 means no grant.
   function automatic logic [23:0] exp_vec(input int g, input int c);
      logic [15:0] gv;
      if (g < 0) return {16'h0000, 4'hF, 1'b0, 3'd0};
      gv = 16'h0001 << g;
      return {gv, 4'(g), 1'b1, 3'(c)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 16'h0000;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [23:0] e;
      rst = 1'b1;
      req = 16'hFFFF;
      tick();
      tick();
      e = exp_vec(-1, 0);
      n_total++;
      if (obs !== e) $display("FAIL reset_outputs: got %h expected %h", obs, e);
      else n_pass++;
      rst = 1'b0;
      req = 16'h0000;
      tick();
      n_total++;
      if (obs !== e) $display("FAIL reset_idle_noreq: got %h expected %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_single_hold();
      logic [23:0] e;
      do_reset();
      req = 16'h0020;
      for (int c = 0; c < 8; c++) begin
         tick();
         e = exp_vec(5, c);
         n_total++;
         if (obs !== e) $display("FAIL single_hold_c%0d: got %h expected %h", c, obs, e);
         else n_pass++;
      end
      tick();
      e = exp_vec(-1, 0);
      n_total++;
      if (obs !== e) $display("FAIL single_turnaround: got %h expected %h", obs, e);
      else n_pass++;
      tick();
      e = exp_vec(5, 0);
      n_total++;
      if (obs !== e) $display("FAIL single_regrant: got %h expected %h", obs, e);
      else n_pass++;
      req = 16'h0000;
      tick();
      e = exp_vec(-1, 0);
      n_total++;
      if (obs !== e) $display("FAIL single_drop: got %h expected %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_alternate();
      logic [23:0] e;
      int g;
      do_reset();
      req = 16'h8001;
      for (int r = 0; r < 3; r++) begin
         g = (r % 2 == 1) ? 15 : 0;
         for (int c = 0; c < 8; c++) begin
            tick();
            e = exp_vec(g, c);
            n_total++;
            if (obs !== e) $display("FAIL alt_r%0d_c%0d: got %h expected %h", r, c, obs, e);
            else n_pass++;
         end
         tick();
         e = exp_vec(-1, 0);
         n_total++;
         if (obs !== e) $display("FAIL alt_idle_r%0d: got %h expected %h", r, obs, e);
         else n_pass++;
      end
      req = 16'h0000;
      tick();
   endtask

   task automatic test_early_drop();
      logic [23:0] e;
      do_reset();
      req = 16'h0008;
      tick();
      tick();
      e = exp_vec(3, 1);
      n_total++;
      if (obs !== e) $display("FAIL drop_hold1: got %h expected %h", obs, e);
      else n_pass++;
      req = 16'h0000;
      tick();
      e = exp_vec(-1, 0);
      n_total++;
      if (obs !== e) $display("FAIL drop_release: got %h expected %h", obs, e);
      else n_pass++;
      req = 16'h0018;
      tick();
      e = exp_vec(4, 0);
      n_total++;
      if (obs !== e) $display("FAIL drop_next_is_4: got %h expected %h", obs, e);
      else n_pass++;
      req = 16'h0000;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_grant();
      logic [23:0] e;
      do_reset();
      req = 16'h0080;
      for (int c = 0; c < 5; c++) tick();
      e = exp_vec(7, 4);
      n_total++;
      if (obs !== e) $display("FAIL midrst_pre: got %h expected %h", obs, e);
      else n_pass++;
      rst = 1'b1;
      req = 16'h0081;
      tick();
      e = exp_vec(-1, 0);
      n_total++;
      if (obs !== e) $display("FAIL midrst_cleared: got %h expected %h", obs, e);
      else n_pass++;
      rst = 1'b0;
      tick();
      e = exp_vec(0, 0);
      n_total++;
      if (obs !== e) $display("FAIL midrst_grant0: got %h expected %h", obs, e);
      else n_pass++;
      req = 16'h0000;
      tick();
      tick();
   endtask

   task automatic test_ignore_others();
      logic [23:0] e;
      do_reset();
      req = 16'h0004;
      tick();
      e = exp_vec(2, 0);
      n_total++;
      if (obs !== e) $display("FAIL ign_grant2: got %h expected %h", obs, e);
      else n_pass++;
      req = 16'h0204;
      tick();
      e = exp_vec(2, 1);
      n_total++;
      if (obs !== e) $display("FAIL ign_pulse9: got %h expected %h", obs, e);
      else n_pass++;
      req = 16'h0004;
      tick();
      e = exp_vec(2, 2);
      n_total++;
      if (obs !== e) $display("FAIL ign_hold2: got %h expected %h", obs, e);
      else n_pass++;
      req = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         e = exp_vec(-1, 0);
         n_total++;
         if (obs !== e) $display("FAIL ign_idle_%0d: got %h expected %h", i, obs, e);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      req     = 16'h0000;
      test_reset();
      test_single_hold();
      test_alternate();
      test_early_drop();
      test_reset_mid_grant();
      test_ignore_others();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
